// File: rtl/rsa_pkg.sv
// Shared types and constants for the modular-exponentiation engine.
// The latency helper is used by the engine's users to size their wait windows.
package rsa_pkg;

  localparam int RSA_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    TO_MONT,
    INIT_ONE,
    SQUARE,
    MULT,
    FROM_MONT
  } modexp_state_t;

  typedef enum logic [1:0] {
    M_IDLE,
    M_RUN,
    M_CORR
  } mult_phase_t;

  // Cycles from acceptance edge to the edge raising eoc.
  function automatic int unsigned modexp_latency(input int unsigned width, input logic [63:0] e);
    int unsigned ones;
    ones = 0;
    for (int i = 0; i < 64; i++) begin
      if (i < int'(width) && e[i]) ones++;
    end
    return (3 + width + ones) * (width + 2);
  endfunction

endpackage

// File: rtl/rsa_mont_mult.sv
// Bit-serial Montgomery multiplier: result = a*b*2^(-WIDTH) mod p.
// One issue cycle, WIDTH iterations, one correction cycle; done/result valid in the correction cycle.
module rsa_mont_mult import rsa_pkg::*; #(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  localparam int TW = WIDTH + 2;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mult_phase_t      phase_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [TW-1:0]    t_q;
  logic [TW-1:0]    t_add;
  logic [TW-1:0]    t_odd;
  logic [TW-1:0]    t_nxt;
  logic [TW-1:0]    b_ext;
  logic [TW-1:0]    p_ext;
  logic [WIDTH:0]   t_diff;

  assign b_ext = {2'b00, b_q};
  assign p_ext = {2'b00, p};

  // T stays below 2P, so T + B + P < 4P fits in WIDTH+2 bits.
  always_comb begin
    t_add = t_q + (a_q[0] ? b_ext : '0);
    t_odd = t_add + (t_add[0] ? p_ext : '0);
    t_nxt = t_odd >> 1;
  end

  // Final T < 2P fits WIDTH+1 bits; the borrow bit of T-P selects the reduced value.
  assign t_diff = t_q[WIDTH:0] - {1'b0, p};
  assign result = t_diff[WIDTH] ? t_q[WIDTH-1:0] : t_diff[WIDTH-1:0];
  assign done   = (phase_q == M_CORR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= M_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      t_q     <= '0;
    end else if (go) begin
      phase_q <= M_RUN;
      cnt_q   <= CW'(WIDTH - 1);
      a_q     <= a;
      b_q     <= b;
      t_q     <= '0;
    end else begin
      case (phase_q)
        M_RUN: begin
          t_q <= t_nxt;
          a_q <= a_q >> 1;
          if (cnt_q == '0) phase_q <= M_CORR;
          else cnt_q <= cnt_q - 1'b1;
        end
        M_CORR:  phase_q <= M_IDLE;
        default: phase_q <= M_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/rsa_modexp_unit.sv
// Left-to-right square-and-multiply C = M^E mod P in the Montgomery domain,
// sequencing one shared rsa_mont_mult; every step is issued the cycle after the previous finishes.
module rsa_modexp_unit import rsa_pkg::*; #(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] m,
  input  logic [WIDTH-1:0] r2,
  output logic             busy,
  output logic             eoc,
  output logic [WIDTH-1:0] c
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  modexp_state_t    state_q, state_nxt;
  logic             issue_q, issue_nxt;
  logic             accept;
  logic             bit_dec;
  logic [CW-1:0]    bit_q;
  logic [WIDTH-1:0] p_q, e_q, m_q, r2_q;
  logic [WIDTH-1:0] mb_q, x_q;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH-1:0] mont_res;
  logic             mont_done;

  rsa_mont_mult #(.WIDTH(WIDTH)) u_mult (
    .clk    (clk),
    .rst    (rst),
    .go     (issue_q),
    .a      (op_a),
    .b      (op_b),
    .p      (p_q),
    .result (mont_res),
    .done   (mont_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      issue_q <= 1'b0;
    end else begin
      state_q <= state_nxt;
      issue_q <= issue_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    issue_nxt = 1'b0;
    accept    = 1'b0;
    bit_dec   = 1'b0;
    op_a      = '0;
    op_b      = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = TO_MONT;
          issue_nxt = 1'b1;
        end
      end
      TO_MONT: begin
        op_a = m_q;
        op_b = r2_q;
        if (mont_done) begin
          state_nxt = INIT_ONE;
          issue_nxt = 1'b1;
        end
      end
      INIT_ONE: begin
        op_a = ONE;
        op_b = r2_q;
        if (mont_done) begin
          state_nxt = SQUARE;
          issue_nxt = 1'b1;
        end
      end
      SQUARE: begin
        op_a = x_q;
        op_b = x_q;
        if (mont_done) begin
          issue_nxt = 1'b1;
          if (e_q[bit_q]) begin
            state_nxt = MULT;
          end else if (bit_q == '0) begin
            state_nxt = FROM_MONT;
          end else begin
            bit_dec = 1'b1;
          end
        end
      end
      MULT: begin
        op_a = x_q;
        op_b = mb_q;
        if (mont_done) begin
          issue_nxt = 1'b1;
          if (bit_q == '0) begin
            state_nxt = FROM_MONT;
          end else begin
            state_nxt = SQUARE;
            bit_dec   = 1'b1;
          end
        end
      end
      FROM_MONT: begin
        op_a = x_q;
        op_b = ONE;
        if (mont_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q   <= '0;
      e_q   <= '0;
      m_q   <= '0;
      r2_q  <= '0;
      mb_q  <= '0;
      x_q   <= '0;
      bit_q <= '0;
      c     <= '0;
      eoc   <= 1'b0;
    end else begin
      eoc <= mont_done && (state_q == FROM_MONT);
      if (accept) begin
        p_q   <= p;
        e_q   <= e;
        m_q   <= m;
        r2_q  <= r2;
        bit_q <= CW'(WIDTH - 1);
      end
      if (bit_dec) bit_q <= bit_q - 1'b1;
      if (mont_done) begin
        case (state_q)
          TO_MONT:                 mb_q <= mont_res;
          INIT_ONE, SQUARE, MULT:  x_q  <= mont_res;
          FROM_MONT:               c    <= mont_res;
          default:                 ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rsa_modexp_unit.sv
// Directed bench for rsa_modexp_unit (WIDTH=8): vector table plus
// start-while-busy, mid-run reset and back-to-back sequences.
module tb_rsa_modexp_unit;
  import rsa_pkg::*;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] p;
    logic [W-1:0] e;
    logic [W-1:0] m;
    logic [W-1:0] r2;
    logic [W-1:0] c;
    int           lat;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] p = '0, e = '0, m = '0, r2 = '0;
  logic         busy, eoc;
  logic [W-1:0] c;

  int n_vec = 0;
  int n_err = 0;

  rsa_modexp_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .p     (p),
    .e     (e),
    .m     (m),
    .r2    (r2),
    .busy  (busy),
    .eoc   (eoc),
    .c     (c)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Accept one run and wait for eoc; lat counts edges after the acceptance edge.
  task automatic run_one(input logic [W-1:0] p_i, e_i, m_i, r2_i,
                         output logic [W-1:0] c_o, output int lat_o, output bit busy_ok);
    int limit;
    limit = int'(modexp_latency(W, 64'(e_i))) + 50;
    @(negedge clk);
    p = p_i; e = e_i; m = m_i; r2 = r2_i; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_ok = busy;
    lat_o = 0;
    while (lat_o < limit) begin
      @(posedge clk); #1;
      lat_o++;
      if (eoc) break;
      if (!busy) busy_ok = 1'b0;
    end
    c_o = c;
  endtask

  vec_t vecs[6];

  initial begin
    logic [W-1:0] c_got;
    int           lat;
    bit           bok;
    int           eoc_cnt, t1, t2;

    vecs[0] = '{8'd187, 8'd7,   8'd88,  8'd86, 8'd11,  140};
    vecs[1] = '{8'd187, 8'd23,  8'd11,  8'd86, 8'd88,  150};
    vecs[2] = '{8'd187, 8'd0,   8'd5,   8'd86, 8'd1,   110};
    vecs[3] = '{8'd187, 8'd1,   8'd186, 8'd86, 8'd186, 120};
    vecs[4] = '{8'd251, 8'd10,  8'd2,   8'd25, 8'd20,  130};
    vecs[5] = '{8'd3,   8'd255, 8'd2,   8'd1,  8'd2,   190};

    // Reset state
    #12;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_eoc", 32'(eoc), 32'd0);
    check("reset_c", 32'(c), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_one(vecs[i].p, vecs[i].e, vecs[i].m, vecs[i].r2, c_got, lat, bok);
      check($sformatf("vec%0d_c", i), 32'(c_got), 32'(vecs[i].c));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_busy_during", i), 32'(bok), 32'd1);
      check($sformatf("vec%0d_busy_at_eoc", i), 32'(busy), 32'd0);
      @(posedge clk); #1;
      check($sformatf("vec%0d_eoc_pulse", i), 32'(eoc), 32'd0);
      check($sformatf("vec%0d_c_held", i), 32'(c), 32'(vecs[i].c));
    end

    // Start while busy, operand inputs toggling after acceptance
    @(negedge clk);
    p = 8'd187; e = 8'd7; m = 8'd88; r2 = 8'd86; start = 1'b1;
    @(posedge clk); #1;
    eoc_cnt = 0; t1 = -1;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      start = (cyc == 20);
      m = 8'(cyc);
      e = 8'(cyc * 3);
      if (cyc == 20) begin p = 8'd255; r2 = 8'd1; end
      @(posedge clk); #1;
      if (eoc) begin
        eoc_cnt++;
        if (t1 < 0) t1 = cyc;
      end
    end
    check("busy_start_c", 32'(c), 32'd11);
    check("busy_start_latency", 32'(t1), 32'd140);
    check("busy_start_eoc_count", 32'(eoc_cnt), 32'd1);

    // Reset mid-run: c must drop from its held value to 0
    @(negedge clk);
    p = 8'd187; e = 8'd7; m = 8'd88; r2 = 8'd86; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (50) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_eoc", 32'(eoc), 32'd0);
    check("midrst_c", 32'(c), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_one(8'd187, 8'd7, 8'd88, 8'd86, c_got, lat, bok);
    check("after_rst_c", 32'(c_got), 32'd11);
    check("after_rst_latency", 32'(lat), 32'd140);

    // Back-to-back with start held high
    @(negedge clk);
    p = 8'd187; e = 8'd7; m = 8'd88; r2 = 8'd86; start = 1'b1;
    @(posedge clk); #1;
    eoc_cnt = 0; t1 = -1; t2 = -1;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(posedge clk); #1;
      if (eoc) begin
        eoc_cnt++;
        if (eoc_cnt == 1) t1 = cyc;
        if (eoc_cnt == 2) begin
          t2 = cyc;
          check("b2b_c_second", 32'(c), 32'd11);
        end
      end
    end
    start = 1'b0;
    check("b2b_first_eoc", 32'(t1), 32'd140);
    check("b2b_spacing", 32'(t2 - t1), 32'd141);
    check("b2b_eoc_count", 32'(eoc_cnt), 32'd2);
    check("b2b_busy_third_run", 32'(busy), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
